// File: rtl/ram_refresh_timer.sv
// DRAM refresh request generator: a free-running period counter accrues refresh
// debt that RefAck repays. Define REF_DEBT_EN to let debt accumulate up to MAX_DEBT.
module ram_refresh_timer #(
  parameter int unsigned REF_PERIOD = 375,
  parameter int unsigned URG_DELAY  = 96,
  parameter int unsigned MAX_DEBT   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RefAck,
  input  logic       RefEn,
  output logic       RefReq,
  output logic       RefUrg,
  output logic [1:0] RefDebt,
  output logic       RefMiss
);

  localparam int unsigned PW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int unsigned UW = (URG_DELAY > 0) ? $clog2(URG_DELAY + 1) : 1;
  localparam logic [PW-1:0] PER_RELOAD = PW'(REF_PERIOD - 1);
  localparam logic [UW-1:0] URG_LIMIT  = UW'(URG_DELAY);

`ifdef REF_DEBT_EN
  localparam int unsigned DW = 2;
  localparam logic [DW-1:0] DEBT_SAT = DW'(MAX_DEBT);
`else
  localparam int unsigned DW = 1;
  localparam logic [DW-1:0] DEBT_SAT = 1'b1;
`endif

  if (MAX_DEBT < 1 || MAX_DEBT > 3) begin : g_max_debt_check
    $error("MAX_DEBT must lie in 1..3 to fit RefDebt");
  end

  typedef enum logic [1:0] {IDLE, PEND, URG} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [UW-1:0] urg_cnt_q, urg_cnt_d;
  logic [DW-1:0] debt_q, debt_d;
  logic          req_q, req_d;
  logic          urg_q, urg_d;
  logic          miss_q, miss_d;
  logic          tick;
  logic          multi_debt;

  always_comb begin
    tick  = RefEn && (per_q == '0);
    per_d = per_q;
    if (RefEn) begin
      per_d = tick ? PER_RELOAD : per_q - PW'(1);
    end

    // A tick and an ack in the same cycle cancel; only a lone tick can miss.
    debt_d = debt_q;
    miss_d = miss_q;
    if (tick && !RefAck) begin
      if (debt_q == DEBT_SAT) begin
        miss_d = 1'b1;
      end else begin
        debt_d = debt_q + DW'(1);
      end
    end else if (RefAck && !tick && debt_q != '0) begin
      debt_d = debt_q - DW'(1);
    end

    // Aging restarts on any ack and only begins once a request is pending.
    if (RefAck || debt_d == '0 || state_q == IDLE) begin
      urg_cnt_d = '0;
    end else if (urg_cnt_q >= URG_LIMIT) begin
      urg_cnt_d = urg_cnt_q;
    end else begin
      urg_cnt_d = urg_cnt_q + UW'(1);
    end

`ifdef REF_DEBT_EN
    multi_debt = (debt_d > 2'd1);
`else
    multi_debt = 1'b0;
`endif

    if (debt_d == '0) begin
      state_d = IDLE;
    end else if (multi_debt || urg_cnt_d >= URG_LIMIT) begin
      state_d = URG;
    end else begin
      state_d = PEND;
    end

    req_d = (state_d != IDLE);
    urg_d = (state_d == URG);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      per_q     <= PER_RELOAD;
      urg_cnt_q <= '0;
      debt_q    <= '0;
      state_q   <= IDLE;
      req_q     <= 1'b0;
      urg_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      per_q     <= per_d;
      urg_cnt_q <= urg_cnt_d;
      debt_q    <= debt_d;
      state_q   <= state_d;
      req_q     <= req_d;
      urg_q     <= urg_d;
      miss_q    <= miss_d;
    end
  end

  assign RefReq  = req_q;
  assign RefUrg  = urg_q;
  assign RefMiss = miss_q;
`ifdef REF_DEBT_EN
  assign RefDebt = debt_q;
`else
  assign RefDebt = {1'b0, debt_q};
`endif

endmodule

// File: tb/tb_ram_refresh_timer.sv
// Self-checking bench for ram_refresh_timer: directed scenarios plus a randomized
// run against a counting model of refresh debt and request age.
module tb_ram_refresh_timer;

  localparam int P = 375;
  localparam int U = 96;
`ifdef REF_DEBT_EN
  localparam int SAT = 3;
`else
  localparam int SAT = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RefAck = 1'b0;
  logic       RefEn = 1'b0;
  logic       RefReq;
  logic       RefUrg;
  logic [1:0] RefDebt;
  logic       RefMiss;

  int errors = 0;
  int checks = 0;

  // Model: enabled-cycle count, outstanding debt, age of the oldest request.
  int   m_en;
  int   m_debt;
  int   m_age;
  logic m_miss;
  logic m_req;
  logic m_urg;

  ram_refresh_timer #(.REF_PERIOD(P), .URG_DELAY(U), .MAX_DEBT(3)) dut (
    .CLK(CLK), .RST(RST), .RefAck(RefAck), .RefEn(RefEn),
    .RefReq(RefReq), .RefUrg(RefUrg), .RefDebt(RefDebt), .RefMiss(RefMiss)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic model_step(input logic rst, input logic en, input logic ack);
    bit t;
    int old;
    if (rst) begin
      m_en = 0; m_debt = 0; m_age = 0; m_miss = 1'b0;
    end else begin
      t = en && ((m_en % P) == P - 1);
      if (en) m_en++;
      old = m_debt;
      if (t && !ack) begin
        if (m_debt == SAT) m_miss = 1'b1;
        else m_debt++;
      end else if (ack && !t && m_debt > 0) begin
        m_debt--;
      end
      if (ack || m_debt == 0 || old == 0) m_age = 0;
      else m_age++;
    end
    m_req = (m_debt > 0);
    m_urg = (m_debt >= 2) || (m_debt == 1 && m_age >= U);
  endtask

  task automatic cyc(input logic rst, input logic en, input logic ack);
    @(negedge CLK);
    RST = rst; RefEn = en; RefAck = ack;
    @(posedge CLK);
    model_step(rst, en, ack);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (RefReq !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", RefReq); end
    checks++; if (RefUrg !== 1'b0) begin errors++; $display("FAIL reset_urg got=%b want=0", RefUrg); end
    checks++; if (RefDebt !== 2'd0) begin errors++; $display("FAIL reset_debt got=%0d want=0", RefDebt); end
    checks++; if (RefMiss !== 1'b0) begin errors++; $display("FAIL reset_miss got=%b want=0", RefMiss); end
  endtask

  task automatic test_first_request();
    int n;
    do_reset();
    n = 0;
    while (RefReq !== 1'b1 && n < 2 * P) begin cyc(1'b0, 1'b1, 1'b0); n++; end
    checks++; if (n != P) begin errors++; $display("FAIL first_req_latency got=%0d want=%0d", n, P); end
    checks++; if (RefDebt !== 2'd1) begin errors++; $display("FAIL first_req_debt got=%0d want=1", RefDebt); end
    checks++; if (RefUrg !== 1'b0) begin errors++; $display("FAIL first_req_urg got=%b want=0", RefUrg); end
    n = 0;
    while (RefUrg !== 1'b1 && n < 2 * U) begin cyc(1'b0, 1'b1, 1'b0); n++; end
    checks++; if (n != U) begin errors++; $display("FAIL urg_delay got=%0d want=%0d", n, U); end
  endtask

  task automatic test_ack_clears();
    int   n;
    logic urg_seen;
    do_reset();
    n = 0;
    while (RefReq !== 1'b1 && n < 2 * P) begin cyc(1'b0, 1'b1, 1'b0); n++; end
    n = 0;
    urg_seen = 1'b0;
    repeat (9) begin cyc(1'b0, 1'b1, 1'b0); n++; urg_seen |= RefUrg; end
    cyc(1'b0, 1'b1, 1'b1); n++;
    checks++; if (RefReq !== 1'b0) begin errors++; $display("FAIL ack_req_drop got=%b want=0", RefReq); end
    checks++; if (RefDebt !== 2'd0) begin errors++; $display("FAIL ack_debt got=%0d want=0", RefDebt); end
    while (RefReq !== 1'b1 && n < 2 * P) begin cyc(1'b0, 1'b1, 1'b0); n++; urg_seen |= RefUrg; end
    checks++; if (n != P) begin errors++; $display("FAIL ack_next_req_spacing got=%0d want=%0d", n, P); end
    checks++; if (urg_seen !== 1'b0) begin errors++; $display("FAIL ack_urg_seen got=%b want=0", urg_seen); end
  endtask

  task automatic test_debt_accum();
    do_reset();
    repeat (P) cyc(1'b0, 1'b1, 1'b0);
    checks++; if (RefDebt !== 2'd1) begin errors++; $display("FAIL accum_t1_debt got=%0d want=1", RefDebt); end
    checks++; if (RefMiss !== 1'b0) begin errors++; $display("FAIL accum_t1_miss got=%b want=0", RefMiss); end
    repeat (P) cyc(1'b0, 1'b1, 1'b0);
    checks++; if (RefUrg !== 1'b1) begin errors++; $display("FAIL accum_t2_urg got=%b want=1", RefUrg); end
`ifdef REF_DEBT_EN
    checks++; if (RefDebt !== 2'd2) begin errors++; $display("FAIL accum_t2_debt got=%0d want=2", RefDebt); end
    checks++; if (RefMiss !== 1'b0) begin errors++; $display("FAIL accum_t2_miss got=%b want=0", RefMiss); end
    repeat (P) cyc(1'b0, 1'b1, 1'b0);
    checks++; if (RefDebt !== 2'd3) begin errors++; $display("FAIL accum_t3_debt got=%0d want=3", RefDebt); end
    checks++; if (RefMiss !== 1'b0) begin errors++; $display("FAIL accum_t3_miss got=%b want=0", RefMiss); end
    repeat (P) cyc(1'b0, 1'b1, 1'b0);
    checks++; if (RefDebt !== 2'd3) begin errors++; $display("FAIL accum_t4_debt got=%0d want=3", RefDebt); end
    checks++; if (RefMiss !== 1'b1) begin errors++; $display("FAIL accum_t4_miss got=%b want=1", RefMiss); end
`else
    checks++; if (RefDebt !== 2'd1) begin errors++; $display("FAIL accum_t2_debt got=%0d want=1", RefDebt); end
    checks++; if (RefMiss !== 1'b1) begin errors++; $display("FAIL accum_t2_miss got=%b want=1", RefMiss); end
`endif
  endtask

  task automatic test_tick_ack();
    do_reset();
    repeat (P + U) cyc(1'b0, 1'b1, 1'b0);
    checks++; if (RefUrg !== 1'b1) begin errors++; $display("FAIL tickack_pre_urg got=%b want=1", RefUrg); end
    repeat (P - U - 1) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (RefDebt !== 2'd1) begin errors++; $display("FAIL tickack_debt got=%0d want=1", RefDebt); end
    checks++; if (RefUrg !== 1'b0) begin errors++; $display("FAIL tickack_urg got=%b want=0", RefUrg); end
    checks++; if (RefReq !== 1'b1) begin errors++; $display("FAIL tickack_req got=%b want=1", RefReq); end
    checks++; if (RefMiss !== 1'b0) begin errors++; $display("FAIL tickack_miss got=%b want=0", RefMiss); end
    repeat (U - 1) cyc(1'b0, 1'b1, 1'b0);
    checks++; if (RefUrg !== 1'b0) begin errors++; $display("FAIL tickack_reage_early got=%b want=0", RefUrg); end
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if (RefUrg !== 1'b1) begin errors++; $display("FAIL tickack_reage got=%b want=1", RefUrg); end
  endtask

  task automatic test_ack_at_zero();
    do_reset();
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (RefDebt !== 2'd0) begin errors++; $display("FAIL ackzero_debt got=%0d want=0", RefDebt); end
    checks++; if (RefReq !== 1'b0) begin errors++; $display("FAIL ackzero_req got=%b want=0", RefReq); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (RefDebt !== 2'd0) begin errors++; $display("FAIL ackzero_hold_debt got=%0d want=0", RefDebt); end
    repeat (P - 1) cyc(1'b0, 1'b1, 1'b0);
    checks++; if (RefDebt !== 2'd1) begin errors++; $display("FAIL ackzero_next_debt got=%0d want=1", RefDebt); end
    checks++; if (RefMiss !== 1'b0) begin errors++; $display("FAIL ackzero_miss got=%b want=0", RefMiss); end
  endtask

  task automatic test_refen_hold();
    do_reset();
    repeat (P) cyc(1'b0, 1'b1, 1'b0);
    repeat (1000) cyc(1'b0, 1'b0, 1'b0);
    checks++; if (RefDebt !== 2'd1) begin errors++; $display("FAIL hold_debt got=%0d want=1", RefDebt); end
    checks++; if (RefMiss !== 1'b0) begin errors++; $display("FAIL hold_miss got=%b want=0", RefMiss); end
    checks++; if (RefUrg !== 1'b1) begin errors++; $display("FAIL hold_urg got=%b want=1", RefUrg); end
    repeat (P - 1) cyc(1'b0, 1'b1, 1'b0);
    checks++; if (RefMiss !== 1'b0) begin errors++; $display("FAIL hold_resume_early got=%b want=0", RefMiss); end
    cyc(1'b0, 1'b1, 1'b0);
`ifdef REF_DEBT_EN
    checks++; if (RefDebt !== 2'd2) begin errors++; $display("FAIL hold_resume_debt got=%0d want=2", RefDebt); end
`else
    checks++; if (RefMiss !== 1'b1) begin errors++; $display("FAIL hold_resume_miss got=%b want=1", RefMiss); end
`endif
  endtask

  task automatic test_reset_in_urg();
    int n;
    do_reset();
    n = 0;
    while (RefMiss !== 1'b1 && n < 5 * P) begin cyc(1'b0, 1'b1, 1'b0); n++; end
    checks++; if (RefMiss !== 1'b1 || RefUrg !== 1'b1) begin errors++; $display("FAIL rsturg_pre got=%b%b want=11", RefMiss, RefUrg); end
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if ({RefReq, RefUrg, RefDebt, RefMiss} !== 5'b0) begin
      errors++; $display("FAIL rsturg_outputs got=%b want=00000", {RefReq, RefUrg, RefDebt, RefMiss});
    end
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (RefDebt !== 2'd0 || RefReq !== 1'b0) begin
      errors++; $display("FAIL rsturg_late_ack got=debt%0d req%b want=debt0 req0", RefDebt, RefReq);
    end
  endtask

  task automatic test_random();
    int   lerr;
    int   rate;
    logic en, ack, rst;
    do_reset();
    lerr = 0;
    for (int i = 0; i < 20000 && lerr < 10; i++) begin
      case ((i / 2500) % 3)
        0:       rate = 20;
        1:       rate = 300;
        default: rate = 5000;
      endcase
      en  = ($urandom_range(0, 9) != 0);
      ack = ($urandom_range(0, rate - 1) == 0);
      rst = ($urandom_range(0, 3999) == 0);
      cyc(rst, en, ack);
      checks++; if (RefReq !== m_req) begin errors++; lerr++; $display("FAIL rnd_req cyc=%0d got=%b want=%b", i, RefReq, m_req); end
      checks++; if (RefUrg !== m_urg) begin errors++; lerr++; $display("FAIL rnd_urg cyc=%0d got=%b want=%b", i, RefUrg, m_urg); end
      checks++; if (RefDebt !== 2'(m_debt)) begin errors++; lerr++; $display("FAIL rnd_debt cyc=%0d got=%0d want=%0d", i, RefDebt, m_debt); end
      checks++; if (RefMiss !== m_miss) begin errors++; lerr++; $display("FAIL rnd_miss cyc=%0d got=%b want=%b", i, RefMiss, m_miss); end
    end
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_ack_clears();
    test_debt_accum();
    test_tick_ack();
    test_ack_at_zero();
    test_refen_hold();
    test_reset_in_urg();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_refresh_timer.md
Name: ram_refresh_timer

Overview:
- Generates DRAM refresh requests for the RAM controller. It is the producer end of the RefReqIn/RefUrgIn interface.
- A free-running period counter accrues refresh "debt". The controller pays the debt back by pulsing RefAck once per refresh cycle it performs.
- Requests escalate from polite (RefReq) to urgent (RefUrg) when the debt ages or accumulates, so the controller can preempt bus cycles.

Parameters:
- REF_PERIOD, 375: CLK cycles between refresh ticks (15 us at 25 MHz).
- URG_DELAY, 96: CLK cycles a single outstanding refresh may wait before RefUrg asserts.
- MAX_DEBT, 3: saturation value of the debt counter (used only with REF_DEBT_EN).

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  synchronous active-high reset.
- RefAck  input  1  one-cycle pulse from the RAM controller when a refresh RAS cycle is issued (RS==4 entry).
- RefEn  input  1  0 = period counter holds (refresh disabled during configuration); outstanding debt is retained.
- RefReq  output  1  registered; refresh wanted, non-urgent.
- RefUrg  output  1  registered; refresh overdue, controller must preempt.
- RefDebt  output  2  registered; current outstanding refresh count.
- RefMiss  output  1  registered; sticky, set when a tick occurs while debt is saturated.

Behaviour:
- Reset (RST=1 at posedge):
  - PerCnt <= REF_PERIOD-1, UrgCnt <= 0, Debt <= 0.
  - RefReq, RefUrg and RefMiss <= 0; state IDLE.
- Period counter (PerCnt, ceil(log2 REF_PERIOD) bits):
  - When RefEn=1, decrements each cycle.
  - At 0, produces Tick for one cycle and reloads REF_PERIOD-1; there is no drift.
  - When RefEn=0, PerCnt holds and no Tick is produced.
- Debt update, same posedge:
  - Tick and no Ack: Debt+1, saturating at MAX_DEBT. A Tick at saturation sets RefMiss.
  - Ack and no Tick: Debt-1. An Ack with Debt=0 is ignored and does not underflow.
  - Tick and Ack together: Debt unchanged, UrgCnt cleared.
- State machine, next state from next Debt and UrgCnt:
  - IDLE (Debt=0): RefReq=0, RefUrg=0, UrgCnt held at 0.
  - PEND (Debt=1, UrgCnt<URG_DELAY): RefReq=1, RefUrg=0, UrgCnt increments each cycle.
  - URG (Debt>=2, or Debt=1 and UrgCnt>=URG_DELAY): RefReq=1, RefUrg=1, UrgCnt saturates.
  - Any Ack clears UrgCnt. If debt remains after an Ack, the remaining request ages from 0.
- Latency and output rules:
  - RefReq asserts on the posedge after the Tick cycle, i.e. 1-cycle latency.
  - RefReq/RefUrg deassert on the posedge after the Ack that takes Debt to 0.
  - Outputs are glitch-free registers. The controller's RefDone latch tolerates RefReq staying high for 1 cycle after Ack.
- RefMiss: cleared only by RST.
- Reset mid-request: all requests drop on the next edge. A controller refresh already in flight completes, and its Ack is ignored because Debt=0.

Optional Feature:
- REF_DEBT_EN defined:
  - Debt counts up to MAX_DEBT (at most 3 with a 2-bit RefDebt).
  - Debt>=2 forces URG.
- REF_DEBT_EN undefined:
  - Debt is 1 bit and RefDebt[1] ties to 0.
  - A Tick with Debt=1 sets RefMiss; URG is reached only via URG_DELAY.
  - MAX_DEBT is unused.

Test Plan:
- Reset then RefEn=1, no Ack, REF_PERIOD=375, URG_DELAY=96:
  - RefReq rises at cycle 376.
  - RefUrg rises 96 cycles later.
  - RefDebt=1.
- RefEn=1, Ack pulsed 10 cycles after RefReq: RefReq falls next cycle, RefUrg never asserts, RefDebt=0, the next RefReq comes 375 cycles after the first.
- No Ack for 3 periods with REF_DEBT_EN:
  - RefDebt goes 1, then 2, then 3.
  - RefUrg asserts at the second tick.
  - The fourth tick sets RefMiss, and RefDebt stays 3.
- Without REF_DEBT_EN: the second tick with no Ack sets RefMiss, RefDebt stays 1, RefUrg is already high via URG_DELAY.
- Ack coincident with Tick at Debt=1: Debt stays 1, UrgCnt resets, RefUrg deasserts if it was set by aging.
- Boundary cases:
  - Ack at Debt=0: no change, no underflow.
  - RefEn=0 for 1000 cycles: no Tick, debt retained.
  - RST asserted while URG: all outputs 0 next edge, RefMiss cleared.
